// File: rtl/cpu_host_fifo_bridge_pkg.sv
// -----------------------------------------------------------------------------
// cpu_host_fifo_bridge_pkg
// Shared constants for the CPU mailbox FIFOs: the CPU datapath word width and
// the depths of the request and read FIFOs, plus a helper that gives the width
// of a FIFO pointer (one wrap bit above the index bits).
// -----------------------------------------------------------------------------
package cpu_host_fifo_bridge_pkg;

    localparam int CPU_DATA_WIDTH = 16;
    localparam int REQ_FIFO_DEPTH = 8;
    localparam int RSP_FIFO_DEPTH = 8;

    // Pointer width for a power-of-two FIFO: index bits plus one wrap bit.
    function automatic int fifo_ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/cpu_host_fifo_bridge_sync_fifo_fwft.sv
// -----------------------------------------------------------------------------
// sync_fifo_fwft
// Single-clock first-word-fall-through FIFO. The head word is presented
// combinationally whenever the FIFO is non-empty; it reads as zero when empty.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset (pointers to zero)
//   push_i   in   write wdata_i at the edge (ignored when full)
//   pop_i    in   drop the head word at the edge (ignored when empty)
//   wdata_i  in   WIDTH  word to write
//   rdata_o  out  WIDTH  head word (show-ahead), zero when empty
//   full_o   out  FIFO holds DEPTH words
//   empty_o  out  FIFO holds no words
//   count_o  out  occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo_fwft
    import cpu_host_fifo_bridge_pkg::*;
#(
    parameter int WIDTH = CPU_DATA_WIDTH,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = fifo_ptr_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    rd_ptr_d;
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;

    assign empty_s = (wr_ptr_q == rd_ptr_q);
    // Same slot index but opposite wrap bit: writer is a full lap ahead.
    assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_s  = push_i && !full_s;
    assign pop_s   = pop_i && !empty_s;

    // Next-state pointers: each advances only on an accepted operation.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers with asynchronous reset; reset empties the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents need no reset because empty masks the head.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    assign rdata_o = empty_s ? {WIDTH{1'b0}} : mem_q[rd_ptr_q[AW-1:0]];
    assign full_o  = full_s;
    assign empty_o = empty_s;
    assign count_o = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/cpu_host_fifo_bridge.sv
// -----------------------------------------------------------------------------
// cpu_host_fifo_bridge
// Host-side owner of the two CPU mailbox FIFOs.
//   Request FIFO: host writes via valid/ready, CPU drains with LOAD_FIFO
//                 (req_fifo_deq) reading the show-ahead head req_fifo_q.
//   Read FIFO:    CPU fills with STORE_FIFO (read_fifo_enq/read_fifo_data),
//                 host drains via host_rsp_valid/host_rsp_ready.
// proto_err is a sticky flag raised when the CPU dequeues an empty request
// FIFO or enqueues into a full read FIFO; the offending operation is dropped.
//
// Ports:
//   clk, rst                          clock, async active-high reset
//   host_req_data/valid/ready         host request stream (ready = !full)
//   req_fifo_empty/deq/q              CPU side of the request FIFO
//   read_fifo_wrfull/enq/data         CPU side of the read FIFO
//   host_rsp_data/valid/ready         host response stream (valid = !empty)
//   req_count, rsp_count              FIFO occupancies
//   proto_err                         sticky protocol-violation flag
// -----------------------------------------------------------------------------
module cpu_host_fifo_bridge
    import cpu_host_fifo_bridge_pkg::*;
#(
    parameter int DATA_WIDTH = CPU_DATA_WIDTH,
    parameter int REQ_DEPTH  = REQ_FIFO_DEPTH,
    parameter int RSP_DEPTH  = RSP_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        host_req_data,
    input  logic                         host_req_valid,
    output logic                         host_req_ready,
    output logic                         req_fifo_empty,
    input  logic                         req_fifo_deq,
    output logic [DATA_WIDTH-1:0]        req_fifo_q,
    output logic                         read_fifo_wrfull,
    input  logic                         read_fifo_enq,
    input  logic [DATA_WIDTH-1:0]        read_fifo_data,
    output logic [DATA_WIDTH-1:0]        host_rsp_data,
    output logic                         host_rsp_valid,
    input  logic                         host_rsp_ready,
    output logic [$clog2(REQ_DEPTH):0]   req_count,
    output logic [$clog2(RSP_DEPTH):0]   rsp_count,
    output logic                         proto_err
);

    logic req_full_s;
    logic req_empty_s;
    logic req_push_s;
    logic req_pop_s;
    logic rsp_full_s;
    logic rsp_empty_s;
    logic rsp_push_s;
    logic rsp_pop_s;
    logic proto_err_q;
    logic proto_err_d;

    assign req_push_s = host_req_valid && !req_full_s;
    assign req_pop_s  = req_fifo_deq && !req_empty_s;
    assign rsp_push_s = read_fifo_enq && !rsp_full_s;
    assign rsp_pop_s  = host_rsp_ready && !rsp_empty_s;

    sync_fifo_fwft #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (req_push_s),
        .pop_i   (req_pop_s),
        .wdata_i (host_req_data),
        .rdata_o (req_fifo_q),
        .full_o  (req_full_s),
        .empty_o (req_empty_s),
        .count_o (req_count)
    );

    sync_fifo_fwft #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rsp_push_s),
        .pop_i   (rsp_pop_s),
        .wdata_i (read_fifo_data),
        .rdata_o (host_rsp_data),
        .full_o  (rsp_full_s),
        .empty_o (rsp_empty_s),
        .count_o (rsp_count)
    );

    // Sticky error: any CPU operation against the wrong FIFO state latches it.
    always_comb begin
        proto_err_d = proto_err_q;
        if ((req_fifo_deq && req_empty_s) || (read_fifo_enq && rsp_full_s)) begin
            proto_err_d = 1'b1;
        end else begin
            proto_err_d = proto_err_q;
        end
    end

    // proto_err register; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            proto_err_q <= 1'b0;
        end else begin
            proto_err_q <= proto_err_d;
        end
    end

    assign host_req_ready   = !req_full_s;
    assign req_fifo_empty   = req_empty_s;
    assign read_fifo_wrfull = rsp_full_s;
    assign host_rsp_valid   = !rsp_empty_s;
    assign proto_err        = proto_err_q;

endmodule

// File: tb/tb_cpu_host_fifo_bridge.sv
// -----------------------------------------------------------------------------
// tb_cpu_host_fifo_bridge
// Directed and random stimulus against a queue-based model of the two
// mailbox FIFOs. Outputs are compared on the falling edge.
// -----------------------------------------------------------------------------
module tb_cpu_host_fifo_bridge;

    localparam int DW   = 16;
    localparam int REQD = 8;
    localparam int RSPD = 8;

    logic          clk;
    logic          rst;
    logic [DW-1:0] host_req_data;
    logic          host_req_valid;
    logic          host_req_ready;
    logic          req_fifo_empty;
    logic          req_fifo_deq;
    logic [DW-1:0] req_fifo_q;
    logic          read_fifo_wrfull;
    logic          read_fifo_enq;
    logic [DW-1:0] read_fifo_data;
    logic [DW-1:0] host_rsp_data;
    logic          host_rsp_valid;
    logic          host_rsp_ready;
    logic [3:0]    req_count;
    logic [3:0]    rsp_count;
    logic          proto_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] m_req[$];
    logic [DW-1:0] m_rsp[$];
    logic          m_err;

    cpu_host_fifo_bridge #(
        .DATA_WIDTH (DW),
        .REQ_DEPTH  (REQD),
        .RSP_DEPTH  (RSPD)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .host_req_data    (host_req_data),
        .host_req_valid   (host_req_valid),
        .host_req_ready   (host_req_ready),
        .req_fifo_empty   (req_fifo_empty),
        .req_fifo_deq     (req_fifo_deq),
        .req_fifo_q       (req_fifo_q),
        .read_fifo_wrfull (read_fifo_wrfull),
        .read_fifo_enq    (read_fifo_enq),
        .read_fifo_data   (read_fifo_data),
        .host_rsp_data    (host_rsp_data),
        .host_rsp_valid   (host_rsp_valid),
        .host_rsp_ready   (host_rsp_ready),
        .req_count        (req_count),
        .rsp_count        (rsp_count),
        .proto_err        (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int rq;
        int rs;
        rq = m_req.size();
        rs = m_rsp.size();
        chk("host_req_ready",   32'(host_req_ready),   32'(rq < REQD));
        chk("req_fifo_empty",   32'(req_fifo_empty),   32'(rq == 0));
        chk("req_fifo_q",       32'(req_fifo_q),       (rq > 0) ? 32'(m_req[0]) : 32'd0);
        chk("req_count",        32'(req_count),        32'(rq));
        chk("read_fifo_wrfull", 32'(read_fifo_wrfull), 32'(rs == RSPD));
        chk("host_rsp_valid",   32'(host_rsp_valid),   32'(rs > 0));
        chk("host_rsp_data",    32'(host_rsp_data),    (rs > 0) ? 32'(m_rsp[0]) : 32'd0);
        chk("rsp_count",        32'(rsp_count),        32'(rs));
        chk("proto_err",        32'(proto_err),        32'(m_err));
    endtask

    // One rising edge: model applies the FIFO rules to the current inputs,
    // then all outputs are compared on the following falling edge.
    task automatic tick();
        bit req_push;
        bit req_pop;
        bit rsp_push;
        bit rsp_pop;
        @(posedge clk);
        req_push = host_req_valid && (m_req.size() < REQD);
        req_pop  = req_fifo_deq && (m_req.size() > 0);
        rsp_push = read_fifo_enq && (m_rsp.size() < RSPD);
        rsp_pop  = host_rsp_ready && (m_rsp.size() > 0);
        if (req_fifo_deq && m_req.size() == 0) m_err = 1'b1;
        if (read_fifo_enq && m_rsp.size() == RSPD) m_err = 1'b1;
        if (req_pop)  void'(m_req.pop_front());
        if (req_push) m_req.push_back(host_req_data);
        if (rsp_pop)  void'(m_rsp.pop_front());
        if (rsp_push) m_rsp.push_back(read_fifo_data);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_inputs();
        host_req_valid = 1'b0;
        host_req_data  = 16'h0000;
        req_fifo_deq   = 1'b0;
        read_fifo_enq  = 1'b0;
        read_fifo_data = 16'h0000;
        host_rsp_ready = 1'b0;
    endtask

    initial begin
        m_err = 1'b0;
        rst   = 1'b1;
        idle_inputs();
        #12;
        check_all();                           // reset state

        @(negedge clk);
        rst = 1'b0;

        // Single push: not visible in push cycle, visible the next
        host_req_data  = 16'h1234;
        host_req_valid = 1'b1;
        chk("empty_in_push_cycle", 32'(req_fifo_empty), 32'd1);
        tick();
        host_req_valid = 1'b0;
        chk("first_word", 32'(req_fifo_q), 32'h1234);
        req_fifo_deq = 1'b1;
        tick();
        req_fifo_deq = 1'b0;

        // Fill request FIFO with 1..8, then try a 9th
        for (int i = 1; i <= 8; i++) begin
            host_req_data  = DW'(i);
            host_req_valid = 1'b1;
            tick();
        end
        chk("req_full_ready", 32'(host_req_ready), 32'd0);
        chk("req_full_count", 32'(req_count), 32'd8);
        host_req_data = 16'h0009;
        tick();                                // 9th must be dropped
        host_req_valid = 1'b0;
        req_fifo_deq   = 1'b1;
        chk("head_after_full", 32'(req_fifo_q), 32'h0001);
        tick();
        chk("ready_after_deq", 32'(host_req_ready), 32'd1);
        for (int i = 0; i < 7; i++) tick();
        req_fifo_deq = 1'b0;
        chk("drained", 32'(req_fifo_empty), 32'd1);

        // Steady state: push and pop every cycle
        for (int i = 0; i <= 20; i++) begin
            host_req_valid = (i < 20);
            host_req_data  = DW'(16'h0100 + i);
            req_fifo_deq   = (i > 0);
            tick();
            if (i > 0 && i < 20) chk("steady_count", 32'(req_count), 32'd1);
        end
        idle_inputs();

        // Dequeue on empty raises proto_err, state unchanged
        req_fifo_deq = 1'b1;
        tick();
        req_fifo_deq = 1'b0;
        chk("proto_err_set", 32'(proto_err), 32'd1);
        tick();
        chk("proto_err_sticky", 32'(proto_err), 32'd1);

        // Read FIFO: enqueue 0xBEEF, then fill to 8
        read_fifo_data = 16'hBEEF;
        read_fifo_enq  = 1'b1;
        tick();
        read_fifo_enq = 1'b0;
        chk("rsp_valid", 32'(host_rsp_valid), 32'd1);
        chk("rsp_beef",  32'(host_rsp_data), 32'hBEEF);
        for (int i = 0; i < 7; i++) begin
            read_fifo_data = DW'($urandom_range(0, 65535));
            read_fifo_enq  = 1'b1;
            tick();
        end
        chk("rsp_wrfull", 32'(read_fifo_wrfull), 32'd1);
        read_fifo_data = 16'hDEAD;
        tick();                                // enqueue while full is dropped
        read_fifo_enq  = 1'b0;
        host_rsp_ready = 1'b1;
        tick();
        host_rsp_ready = 1'b0;
        chk("rsp_wrfull_clear", 32'(read_fifo_wrfull), 32'd0);
        host_rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        idle_inputs();

        // Random traffic on both FIFOs
        for (int i = 0; i < 400; i++) begin
            host_req_valid = ($urandom_range(0, 3) != 0);
            host_req_data  = DW'($urandom_range(0, 65535));
            req_fifo_deq   = ($urandom_range(0, 2) == 0);
            read_fifo_enq  = ($urandom_range(0, 2) != 0);
            read_fifo_data = DW'($urandom_range(0, 65535));
            host_rsp_ready = ($urandom_range(0, 3) == 0);
            tick();
        end
        idle_inputs();

        // Asynchronous reset mid-stream with 5 words queued
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_req.delete();
        m_rsp.delete();
        m_err = 1'b0;
        for (int i = 0; i < 5; i++) begin
            host_req_valid = 1'b1;
            host_req_data  = DW'(16'h0A00 + i);
            read_fifo_enq  = 1'b1;
            read_fifo_data = DW'(16'h0B00 + i);
            tick();
        end
        idle_inputs();
        chk("pre_rst_count", 32'(req_count), 32'd5);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        m_req.delete();
        m_rsp.delete();
        m_err = 1'b0;
        check_all();                           // before any further edge
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_host_fifo_bridge.md
Name: cpu_host_fifo_bridge

Overview:
Host-side owner of the two CPU mailbox FIFOs. The request FIFO is written by the host and drained by the CPU's LOAD_FIFO instruction. The read FIFO is filled by the CPU's STORE_FIFO instruction and drained by the host. The block sits beside the single-cycle CPU core. It presents exactly the empty, dequeue, enqueue and write-full signalling the instruction decoder consumes, and gives the host valid/ready streams.

Parameters:
DATA_WIDTH, CPU_DATA_WIDTH (16), FIFO word width.
REQ_DEPTH, 8, request FIFO entries; power of two, >= 2.
RSP_DEPTH, 8, read FIFO entries; power of two, >= 2.

Ports:
clk  in  1  sole clock, rising edge.
rst  in  1  asynchronous, active-high reset.
host_req_data  in  DATA_WIDTH  host request word.
host_req_valid  in  1  host offers a request word.
host_req_ready  out  1  request FIFO can accept a word (= !req full).
req_fifo_empty  out  1  request FIFO holds no words (to CPU).
req_fifo_deq  in  1  CPU pops the head word this cycle.
req_fifo_q  out  DATA_WIDTH  head of request FIFO, show-ahead.
read_fifo_wrfull  out  1  read FIFO full (to CPU).
read_fifo_enq  in  1  CPU pushes read_fifo_data this cycle.
read_fifo_data  in  DATA_WIDTH  CPU result word (CPU regfile read port).
host_rsp_data  out  DATA_WIDTH  head of read FIFO.
host_rsp_valid  out  1  read FIFO non-empty.
host_rsp_ready  in  1  host accepts the head word.
req_count  out  $clog2(REQ_DEPTH)+1  request FIFO occupancy.
rsp_count  out  $clog2(RSP_DEPTH)+1  read FIFO occupancy.
proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset values (asynchronous, immediate): both FIFOs empty, pointers 0, counts 0. host_req_ready=1, req_fifo_empty=1, read_fifo_wrfull=0, host_rsp_valid=0, proto_err=0. Data outputs are 0.
- Both FIFOs are first-word-fall-through. Head data is valid combinationally whenever the FIFO is not empty. This is required because the single-cycle CPU writes req_fifo_q to the regfile in the same cycle it asserts req_fifo_deq.
- Request push occurs on a rising edge when host_req_valid && host_req_ready. The word becomes visible one edge later: req_fifo_empty falls and req_fifo_q is valid in the cycle after the accepting edge. There is no same-cycle bypass.
- Request pop occurs on a rising edge when req_fifo_deq && !req_fifo_empty. The read pointer advances, and the next word (or empty) appears after that edge.
- Read-FIFO push occurs on a rising edge when read_fifo_enq && !read_fifo_wrfull. read_fifo_data is captured at that edge. host_rsp_valid rises the cycle after.
- Read-FIFO pop occurs on a rising edge when host_rsp_valid && host_rsp_ready.
- A simultaneous push and pop on the same FIFO, when not empty and not full, leaves the count unchanged. Both pointers advance and the data is preserved.
- Empty FIFO with push and pop requested together: only the push takes effect (pop is illegal while empty).
- Full FIFO: ready/wrfull is deasserted, so no push occurs. A pop on a full FIFO is legal and frees one slot for the next cycle.
- Pointers are $clog2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH. full = MSBs differ && LSBs equal; empty = pointers equal. count = wr_ptr - rd_ptr (modular).
- proto_err is set at an edge when req_fifo_deq=1 while req_fifo_empty=1, or read_fifo_enq=1 while read_fifo_wrfull=1. The offending operation is ignored and the FIFO state is unchanged. proto_err clears only on rst.
- Reset mid-operation discards all contents immediately. No word is delivered after rst deasserts until a new push.

Decomposition:
- cpuPkg additions: REQ_FIFO_DEPTH and RSP_FIFO_DEPTH constants, reusing CPU_DATA_WIDTH.
- One sub-module, sync_fifo_fwft (params WIDTH, DEPTH), provides push/pop, full/empty, count and head data. It is instantiated twice.
- The bridge top adds host handshakes, the CPU-side gating and proto_err.

Test Plan:
- Reset then push 0x1234 from the host -> req_fifo_empty=1 in the push cycle; next cycle req_fifo_empty=0, req_fifo_q=0x1234, req_count=1.
- Host pushes 8 words 0x0001..0x0008 with no CPU deq -> host_req_ready=0 after the 8th, req_count=8. A 9th valid is not accepted. A CPU deq returns 0x0001 and ready=1 the next cycle.
- Steady state: host pushes and CPU pops every cycle over 20 words -> output order matches input, req_count stays 1, no proto_err.
- CPU enqueues 0xBEEF, host_rsp_ready=0 -> host_rsp_valid=1 next cycle and holds 0xBEEF. Fill to 8 -> read_fifo_wrfull=1. Host pops one -> wrfull=0 the following cycle.
- CPU asserts req_fifo_deq on an empty FIFO -> proto_err=1 next cycle, pointers unchanged, stays set until rst.
- Assert rst mid-stream with 5 words queued -> counts 0, req_fifo_empty=1, host_rsp_valid=0 immediately, without waiting for a clock edge.
